// File: rtl/ccsds_turbo_pkg.sv
// Shared state encoding, bank-state constants and address widths for the
// CCSDS turbo encoder ping-pong scheduler.
package ccsds_turbo_pkg;

    localparam int IDX_W = 13;
    localparam int BUF_W = 14;

    localparam logic BANK_EMPTY = 1'b0;
    localparam logic BANK_FULL  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_TERM,
        ST_DONE
    } enc_state_t;

endpackage

// File: rtl/ccsds_turbo_bank_wr_ctrl.sv
// Write side of the ping-pong buffer: write index, write bank pointer,
// per-bank FULL flags and the sticky overflow flag.
module ccsds_turbo_bank_wr_ctrl
    import ccsds_turbo_pkg::*;
#(
    parameter int K = 8160
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    input  logic             i_free_en,
    input  logic             i_free_bank,
    output logic             o_in_ready,
    output logic [BUF_W-1:0] o_wr_addr,
    output logic [1:0]       o_bank_full,
    output logic             o_overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    logic [IDX_W-1:0] r_wr_idx;
    logic             r_wr_ptr;
    logic [1:0]       r_bank_full;
    logic             r_overflow;
    logic             w_wr_fire;
    logic             w_last;
    logic [1:0]       w_bank_full_nxt;

    assign o_in_ready  = (r_bank_full[r_wr_ptr] == BANK_EMPTY);
    assign w_wr_fire   = i_in_valid && o_in_ready;
    assign w_last      = (r_wr_idx == LAST_IDX);
    assign o_wr_addr   = {r_wr_ptr, r_wr_idx};
    assign o_bank_full = r_bank_full;
    assign o_overflow  = r_overflow;

    // Reader frees a FULL bank while the writer can only fill an EMPTY one,
    // so the two updates never target the same bank and both must land.
    always_comb begin
        // NOTE: default assigned first so no path leaves the vector unassigned (no latch).
        w_bank_full_nxt = r_bank_full;
        if (i_free_en) begin
            w_bank_full_nxt[i_free_bank] = BANK_EMPTY;
        end
        if (w_wr_fire && w_last) begin
            w_bank_full_nxt[r_wr_ptr] = BANK_FULL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx    <= '0;
            r_wr_ptr    <= 1'b0;
            r_bank_full <= {BANK_EMPTY, BANK_EMPTY};
            r_overflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            r_bank_full <= w_bank_full_nxt;
            if (w_wr_fire) begin
                r_wr_idx <= w_last ? '0 : r_wr_idx + IDX_W'(1);
                if (w_last) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
            end
            if (i_in_valid && !o_in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccsds_turbo_enc_pingpong_sched.sv
// Ping-pong frame scheduler for a CCSDS turbo encoder: sequences ROM, buffer
// fetch, RSC data and termination per frame. Optional CCSDS_TURBO_SCHED_STATS_EN adds frame_cnt.
module ccsds_turbo_enc_pingpong_sched
    import ccsds_turbo_pkg::*;
#(
    parameter int K        = 8160,
    parameter int TERM_LEN = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BUF_W-1:0] wr_addr,
    output logic             rom_en,
    output logic [IDX_W-1:0] rom_addr,
    output logic             fetch_en,
    output logic [BUF_W-1:0] rd_addr,
    output logic             rd_bank,
    output logic             rsc_en,
    output logic             term,
    output logic             enc_done,
    output logic             overflow
`ifdef CCSDS_TURBO_SCHED_STATS_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] C_K         = CNT_W'(K);
    localparam logic [CNT_W-1:0] C_RUN_LAST  = CNT_W'(K + 1);
    localparam logic [CNT_W-1:0] C_TERM_LAST = CNT_W'(TERM_LEN - 1);

    enc_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_rd_ptr, w_rd_ptr_nxt;
    logic             r_rd_bank, w_rd_bank_nxt;
    logic [1:0]       w_bank_full;
    logic             w_free_en;
    logic [IDX_W-1:0] w_rd_idx;

    ccsds_turbo_bank_wr_ctrl #(.K(K)) u_wr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (in_valid),
        .i_free_en   (w_free_en),
        .i_free_bank (r_rd_bank),
        .o_in_ready  (in_ready),
        .o_wr_addr   (wr_addr),
        .o_bank_full (w_bank_full),
        .o_overflow  (overflow)
    );

    assign rd_bank = r_rd_bank;
    assign rd_addr = {r_rd_bank, w_rd_idx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rd_ptr  <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_rd_bank <= w_rd_bank_nxt;
        end
    end

    // RUN cycle c: ROM read at c, buffer fetch one cycle behind, RSC two behind.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_rd_bank_nxt = r_rd_bank;
        rom_en        = 1'b0;
        rom_addr      = '0;
        fetch_en      = 1'b0;
        w_rd_idx      = '0;
        rsc_en        = 1'b0;
        term          = 1'b0;
        enc_done      = 1'b0;
        w_free_en     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_bank_full[r_rd_ptr] == BANK_FULL) begin
                    w_state_nxt   = ST_RUN;
                    w_cnt_nxt     = '0;
                    w_rd_bank_nxt = r_rd_ptr;
                end
            end
            ST_RUN: begin
                rom_en   = (r_cnt < C_K);
                rom_addr = rom_en ? r_cnt[IDX_W-1:0] : '0;
                fetch_en = (r_cnt != '0) && (r_cnt <= C_K);
                w_rd_idx = fetch_en ? r_cnt[IDX_W-1:0] - IDX_W'(1) : '0;
                rsc_en   = (r_cnt >= CNT_W'(2));
                if (r_cnt == C_RUN_LAST) begin
                    w_state_nxt = ST_TERM;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_TERM: begin
                term = 1'b1;
                if (r_cnt == C_TERM_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                enc_done     = 1'b1;
                w_free_en    = 1'b1;
                w_rd_ptr_nxt = ~r_rd_ptr;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef CCSDS_TURBO_SCHED_STATS_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (enc_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_ccsds_turbo_enc_pingpong_sched.sv
// Scoreboard bench for ccsds_turbo_enc_pingpong_sched with K=8, TERM_LEN=4:
// filled banks queue expected frames; the negedge monitor pops and checks every cycle.
module tb_ccsds_turbo_enc_pingpong_sched;

    localparam int K        = 8;
    localparam int TERM_LEN = 4;
    // DONE is frame cycle 14 counting RUN entry as 0, i.e. the 15th cycle of the frame.
    localparam int DONE_C   = K + 2 + TERM_LEN;

    typedef struct {
        logic bank;
        int   ready_cyc;
    } frame_exp_t;

    logic        clk, rst, in_valid;
    logic        in_ready, rom_en, fetch_en, rd_bank, rsc_en, term, enc_done, overflow;
    logic [13:0] wr_addr, rd_addr;
    logic [12:0] rom_addr;
`ifdef CCSDS_TURBO_SCHED_STATS_EN
    logic [15:0] frame_cnt;
`endif

    int         n_checks    = 0;
    int         n_fail      = 0;
    int         cyc         = 0;
    frame_exp_t sb_q[$];
    frame_exp_t mon_e;
    logic [1:0] m_full;
    logic       m_wr_bank;
    int         m_wr_idx;
    logic       exp_ovf;
    int         mon_c       = -1;
    logic       mon_bank;
    int         frames_done = 0;
    int         last_done   = -100;
    int         last_wr_cyc = 0;

    ccsds_turbo_enc_pingpong_sched #(.K(K), .TERM_LEN(TERM_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_addr  (wr_addr),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .fetch_en (fetch_en),
        .rd_addr  (rd_addr),
        .rd_bank  (rd_bank),
        .rsc_en   (rsc_en),
        .term     (term),
        .enc_done (enc_done),
        .overflow (overflow)
`ifdef CCSDS_TURBO_SCHED_STATS_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [32:0] exp_vec(input int c, input logic bank);
        logic        ren, fen, sen, ten, den;
        logic [12:0] ra, ri;
        ren = (c < K);
        ra  = ren ? 13'(c) : 13'd0;
        fen = (c >= 1) && (c <= K);
        ri  = fen ? 13'(c - 1) : 13'd0;
        sen = (c >= 2) && (c <= K + 1);
        ten = (c >= K + 2) && (c < K + 2 + TERM_LEN);
        den = (c == DONE_C);
        return {ren, ra, fen, bank, ri, sen, ten, den, bank};
    endfunction

    function automatic logic [32:0] obs_vec();
        return {rom_en, rom_addr, fetch_en, rd_addr, rsc_en, term, enc_done, rd_bank};
    endfunction

    function automatic logic [47:0] reset_vec();
        return {enc_done, rom_en, rom_addr, fetch_en, rd_addr, rd_bank,
                rsc_en, term, overflow, wr_addr};
    endfunction

    // Monitor: frame start time, per-cycle frame outputs, idle quiet, reset quiet.
    always @(negedge clk) begin
        if (rst) begin
            mon_c = -1;
            check("rst_outs", 64'(reset_vec()), 64'(0));
        end else begin
            if (mon_c < 0 && rom_en) begin
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0) begin
                    mon_e    = sb_q.pop_front();
                    mon_bank = mon_e.bank;
                    check("run_start_cyc", 64'(cyc),
                          64'((mon_e.ready_cyc > last_done + 2) ? mon_e.ready_cyc : last_done + 2));
                    mon_c = 0;
                end
            end
            if (mon_c >= 0) begin
                check("frame_outs", 64'(obs_vec()), 64'(exp_vec(mon_c, mon_bank)));
                if (mon_c == DONE_C) begin
                    frames_done++;
                    last_done        = cyc;
                    m_full[mon_bank] = 1'b0;
                    mon_c            = -1;
                end else begin
                    mon_c++;
                end
            end else begin
                check("idle_outs", 64'({rom_en, rom_addr, fetch_en, rd_addr[12:0],
                                        rsc_en, term, enc_done}), 64'(0));
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_async", 64'(reset_vec()), 64'(0));
        m_full      = 2'b00;
        m_wr_bank   = 1'b0;
        m_wr_idx    = 0;
        exp_ovf     = 1'b0;
        frames_done = 0;
        last_done   = -100;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("ready_after_rst", 64'(in_ready), 64'(1));
    endtask

    // Handshaked source: writes only when the bench expects the bank to be free.
    task automatic push_bits(input int n);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 400) begin
            @(posedge clk);
            #1;
            check("in_ready", 64'(in_ready), 64'(m_full[m_wr_bank] == 1'b0));
            check("overflow", 64'(overflow), 64'(exp_ovf));
            if (m_full[m_wr_bank] == 1'b0) begin
                check("wr_addr", 64'(wr_addr), 64'({m_wr_bank, 13'(m_wr_idx)}));
                in_valid    = 1'b1;
                last_wr_cyc = cyc;
                if (m_wr_idx == K - 1) begin
                    sb_q.push_back('{bank: m_wr_bank, ready_cyc: cyc + 2});
                    m_full[m_wr_bank] = 1'b1;
                    m_wr_bank         = ~m_wr_bank;
                    m_wr_idx          = 0;
                end else begin
                    m_wr_idx++;
                end
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            guard++;
        end
        check("push_count", 64'(sent), 64'(n));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic force_write();
        @(posedge clk);
        #1;
        check("in_ready_blocked", 64'(in_ready), 64'(m_full[m_wr_bank] == 1'b0));
        check("wr_addr_before", 64'(wr_addr), 64'({m_wr_bank, 13'(m_wr_idx)}));
        in_valid = 1'b1;
        if (m_full[m_wr_bank]) exp_ovf = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("overflow_set", 64'(overflow), 64'(exp_ovf));
        check("wr_addr_hold", 64'(wr_addr), 64'({m_wr_bank, 13'(m_wr_idx)}));
    endtask

    task automatic wait_frames(input int n);
        int g = 0;
        while (frames_done < n && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("frames_done", 64'(frames_done), 64'(n));
    endtask

    initial begin
        int l0;
        int done0;
        int g;
        rst      = 1'b0;
        in_valid = 1'b0;
        #2;

        // Single frame on bank 0.
        do_reset();
        push_bits(K);
        wait_frames(1);

        // 24 continuous bits: banks 0, 1, 0 with back-pressure and 2-cycle gaps.
        do_reset();
        push_bits(3 * K);
        wait_frames(3);
`ifdef CCSDS_TURBO_SCHED_STATS_EN
        check("frame_cnt", 64'(frame_cnt), 64'(3));
`endif

        // Write while both banks are FULL.
        do_reset();
        push_bits(2 * K);
        force_write();
        force_write();
        push_bits(K);
        check("overflow_sticky", 64'(overflow), 64'(1));
        wait_frames(3);

        // Bank 0 DONE in the same cycle as the final write to bank 1.
        do_reset();
        push_bits(K);
        l0 = last_wr_cyc;
        repeat (l0 + 8 - cyc) @(posedge clk);
        #1;
        push_bits(K);
        done0 = last_done;
        check("done_wr_coincide", 64'(done0), 64'(last_wr_cyc));
        check("bank0_free", 64'(in_ready), 64'(m_full[m_wr_bank] == 1'b0));
        wait_frames(2);

        // Reset in the middle of RUN aborts the frame; a fresh frame follows on bank 0.
        do_reset();
        push_bits(K);
        g = 0;
        while (mon_c < 5 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("mid_run_reached", 64'(mon_c >= 5), 64'(1));
        do_reset();
        check("aborted_frames", 64'(frames_done), 64'(0));
        push_bits(K);
        wait_frames(1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
